// File: rtl/activity_pkg.sv
// Shared types and helpers for the activity reporter: channel state encoding,
// counter widths and saturating increments.
package activity_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_LOST   = 2'd2
    } chan_state_e;

    localparam int RISE_W = 16;
    localparam int SECS_W = 32;

    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [RISE_W-1:0] sat_inc_rise(input logic [RISE_W-1:0] v);
        return (&v) ? v : v + RISE_W'(1);
    endfunction

    function automatic logic [SECS_W-1:0] sat_inc_secs(input logic [SECS_W-1:0] v);
        return (&v) ? v : v + SECS_W'(1);
    endfunction

endpackage

// File: rtl/activity_chan.sv
// One monitored channel: edge detection on 'active', idle/active/lost FSM,
// activation and active-seconds counters, and the registered LED drive.
module activity_chan
    import activity_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              active,
    input  logic              clear,
    input  logic              sec_tick,
    input  logic              blink_phase,
    output logic              led,
    output logic              lost,
    output logic              lose_event,
    output logic [RISE_W-1:0] rise_count,
    output logic [SECS_W-1:0] active_secs
);

    chan_state_e       state_q, state_d;
    logic              active_q;
    logic              rise;
    logic              led_q, led_d;
    logic [RISE_W-1:0] rise_count_q, rise_count_d;
    logic [SECS_W-1:0] active_secs_q, active_secs_d;

    // Next state, counter updates and LED value; clear overrides any same-cycle increment.
    always_comb begin
        rise          = active & ~active_q;
        state_d       = state_q;
        led_d         = 1'b0;
        rise_count_d  = rise_count_q;
        active_secs_d = active_secs_q;

        case (state_q)
            ST_IDLE:   if (active) state_d = ST_ACTIVE;
            ST_ACTIVE: if (!active) state_d = ST_LOST;
            ST_LOST: begin
                if (active)     state_d = ST_ACTIVE;
                else if (clear) state_d = ST_IDLE;
            end
            default:   state_d = ST_IDLE;
        endcase

        case (state_q)
            ST_ACTIVE: led_d = blink_phase;
            ST_LOST:   led_d = 1'b1;
            default:   led_d = 1'b0;
        endcase

        if (clear) begin
            rise_count_d  = '0;
            active_secs_d = '0;
        end else begin
            if (rise)
                rise_count_d = sat_inc_rise(rise_count_q);
            if (sec_tick && active)
                active_secs_d = sat_inc_secs(active_secs_q);
        end
    end

    // Channel state and counters; async reset returns everything to idle/zero.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            active_q      <= 1'b0;
            led_q         <= 1'b0;
            rise_count_q  <= '0;
            active_secs_q <= '0;
        end else begin
            state_q       <= state_d;
            active_q      <= active;
            led_q         <= led_d;
            rise_count_q  <= rise_count_d;
            active_secs_q <= active_secs_d;
        end
    end

    assign lose_event  = (state_q == ST_ACTIVE) && !active;
    assign lost        = (state_q == ST_LOST);
    assign led         = led_q;
    assign rise_count  = rise_count_q;
    assign active_secs = active_secs_q;

endmodule

// File: rtl/activity_reporter.sv
// Top level: shared one-second prescaler and LED blink divider, one
// activity_chan per monitored stream, and a single merged loss interrupt.
module activity_reporter
    import activity_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int FREQ_HZ  = 332265625,
    parameter int BLINK_HZ = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [CHANNELS-1:0]        active,
    input  logic                       clear,
    output logic [CHANNELS-1:0]        led,
    output logic [CHANNELS-1:0]        lost,
    output logic [CHANNELS*RISE_W-1:0] rise_count,
    output logic [CHANNELS*SECS_W-1:0] active_secs,
    output logic                       irq
);

    localparam int SEC_CW     = (FREQ_HZ > 1) ? $clog2(FREQ_HZ) : 1;
    localparam int BLINK_HALF = (FREQ_HZ / (2 * BLINK_HZ) > 0) ? FREQ_HZ / (2 * BLINK_HZ) : 1;
    localparam int BLINK_CW   = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    logic [SEC_CW-1:0]   sec_cnt_q, sec_cnt_d;
    logic [BLINK_CW-1:0] blink_cnt_q, blink_cnt_d;
    logic                blink_phase_q, blink_phase_d;
    logic                sec_tick;
    logic                blink_wrap;
    logic                irq_q, irq_d;
    logic [CHANNELS-1:0] lose_vec;

    // Divider wrap detection and next counts; irq merges every channel's loss into one pulse.
    always_comb begin
        sec_tick      = (sec_cnt_q == SEC_CW'(FREQ_HZ - 1));
        blink_wrap    = (blink_cnt_q == BLINK_CW'(BLINK_HALF - 1));
        sec_cnt_d     = sec_tick ? '0 : sec_cnt_q + SEC_CW'(1);
        blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + BLINK_CW'(1);
        blink_phase_d = blink_wrap ? ~blink_phase_q : blink_phase_q;
        irq_d         = |lose_vec;
    end

    // Shared dividers and the registered interrupt pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sec_cnt_q     <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            irq_q         <= 1'b0;
        end else begin
            sec_cnt_q     <= sec_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            irq_q         <= irq_d;
        end
    end

    assign irq = irq_q;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            activity_chan u_chan (
                .clk         (clk),
                .resetn      (resetn),
                .active      (active[gi]),
                .clear       (clear),
                .sec_tick    (sec_tick),
                .blink_phase (blink_phase_q),
                .led         (led[gi]),
                .lost        (lost[gi]),
                .lose_event  (lose_vec[gi]),
                .rise_count  (rise_count[gi*RISE_W +: RISE_W]),
                .active_secs (active_secs[gi*SECS_W +: SECS_W])
            );
        end
    endgenerate

endmodule
